pipe_rr_arbiter: RTL and testbench

//  Shares one two-stage registered pipeline (S1 -> S2, one flop per stage) among
//  N_REQ requesters. Each cycle it grants at most one requester, round-robin.
//  It tags each accepted word with the source index and applies out_ready

---
 rtl/pipe_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_pipe_rr_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter feeding a two-stage registered pipeline (S1 -> S2).
// Grants are suppressed whenever S1 cannot advance; each stage carries payload and source tag.
module pipe_rr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
    input  logic                      out_ready,
    output logic                      busy
);

    // (base + off) mod N_REQ, so the scan wraps correctly even for non power-of-two N_REQ
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        return ID_W'(sum % 32'(N_REQ));
    endfunction

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic [ID_W-1:0]   s2_id_q, s2_id_d;
    logic              busy_q, busy_d;

    logic              s2_adv_s;
    logic              s1_adv_s;
    logic              grant_s;
    logic [ID_W-1:0]   gnt_idx_s;
    logic [N_REQ-1:0]  gnt_s;
    logic [ID_W-1:0]   cand_s;

    assign s2_adv_s = !s2_valid_q | out_ready;
    assign s1_adv_s = !s1_valid_q | s2_adv_s;

    // Round-robin scan starting at ptr; no grant while S1 is blocked or in reset
    always_comb begin
        grant_s   = 1'b0;
        gnt_idx_s = '0;
        gnt_s     = '0;
        cand_s    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand_s = wrap_idx(ptr_q, k);
            if (!grant_s && req[cand_s] && s1_adv_s && rst_n) begin
                grant_s   = 1'b1;
                gnt_idx_s = cand_s;
            end else begin
                grant_s   = grant_s;
            end
        end
        if (grant_s) begin
            gnt_s[gnt_idx_s] = 1'b1;
            ptr_d            = wrap_idx(gnt_idx_s, 32'd1);
        end else begin
            gnt_s            = '0;
            ptr_d            = ptr_q;
        end
    end

    // Next-state for both pipeline stages and the busy flag
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_data_q;
            s2_id_d    = s1_id_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end
        if (s1_adv_s) begin
            s1_valid_d = grant_s;
            if (grant_s) begin
                s1_data_d = req_data[32'(gnt_idx_s)*DATA_W +: DATA_W];
                s1_id_d   = gnt_idx_s;
            end else begin
                s1_data_d = s1_data_q;
                s1_id_d   = s1_id_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
        busy_d = s1_valid_d | s2_valid_d;
    end

    // State registers; async reset discards any in-flight words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt       = gnt_s;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_id    = s2_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Bench for pipe_rr_arbiter: a grant-order queue model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pipe_rr_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_id;
    logic           out_ready;
    logic           busy;

    int errors = 0;
    int checks = 0;

    pipe_rr_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: words in flight kept in grant order, each stamped with its grant cycle.
    typedef struct {
        logic [7:0] data;
        int         id;
        int         g;
    } word_t;
    word_t      mq[$];
    int         m_ptr = 0;
    int         edge_cnt = 0;
    bit         p_push, p_pop;
    int         p_id;
    logic [7:0] p_data;

    always @(negedge clk) begin
        logic [N-1:0] eg;
        int gi;
        bit vis;
        p_push = 1'b0;
        p_pop  = 1'b0;
        eg     = '0;
        gi     = -1;
        if (!rst_n) begin
            chk("m_rst_gnt", gnt, 0);
            chk("m_rst_valid", out_valid, 0);
            chk("m_rst_busy", busy, 0);
            chk("m_rst_data", out_data, 0);
            chk("m_rst_id", out_id, 0);
        end else begin
            if (mq.size() < 2 || out_ready) begin
                for (int k = 0; k < N; k++)
                    if (gi < 0 && req[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
            end
            if (gi >= 0) eg[gi] = 1'b1;
            vis = (mq.size() > 0) && (edge_cnt >= mq[0].g + 2);
            chk("m_gnt", gnt, eg);
            chk("m_valid", out_valid, vis);
            chk("m_busy", busy, mq.size() > 0);
            if (vis) begin
                chk("m_data", out_data, mq[0].data);
                chk("m_id", out_id, mq[0].id);
            end
            p_pop = vis && out_ready;
            if (gi >= 0) begin
                p_push = 1'b1;
                p_id   = gi;
                p_data = req_data[gi*W +: W];
            end
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_ptr = 0;
        end else begin
            if (p_pop) void'(mq.pop_front());
            if (p_push) begin
                mq.push_back('{p_data, p_id, edge_cnt});
                m_ptr = (p_id + 1) % N;
            end
        end
        edge_cnt++;
    end

    // Requesters: rem[i] words left, each new word gets a fresh payload after a grant.
    int rem[N];
    int sq[N];

    task automatic load(input int i, input int n);
        rem[i] = n;
        req[i] = (n > 0);
        req_data[i*W +: W] = 8'(i*16 + sq[i]);
    endtask

    task automatic cyc(output logic [N-1:0] g);
        @(negedge clk);
        g = gnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                rem[i]--;
                sq[i]++;
                req_data[i*W +: W] = 8'(i*16 + sq[i]);
                req[i] = (rem[i] > 0);
            end
        end
    endtask

    task automatic run(input int n);
        logic [N-1:0] g;
        repeat (n) cyc(g);
    endtask

    initial begin
        logic [N-1:0] g;
        logic [7:0]   stall_data;
        bit           seen;
        rst_n = 1'b0;
        req = '0;
        req_data = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            sq[i] = 0;
        end

        // reset with all requesting
        for (int i = 0; i < N; i++) load(i, 2);
        cyc(g);
        chk("rst_gnt", g, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        cyc(g);
        rst_n = 1'b1;

        // round-robin from ptr=0
        for (int k = 0; k < 5; k++) begin
            cyc(g);
            chk("rr_gnt", g, 32'(1) << (k % 4));
        end
        run(10);

        // single word latency
        load(2, 1);
        req_data[2*W +: W] = 8'hA5;
        cyc(g);
        chk("lat_gnt", g, 4'b0100);
        chk("lat_v1", out_valid, 0);
        cyc(g);
        chk("lat_v2", out_valid, 1);
        chk("lat_data", out_data, 8'hA5);
        chk("lat_id", out_id, 2);
        cyc(g);
        chk("lat_v3", out_valid, 0);

        // wrap/skip from ptr=3
        load(0, 1);
        load(2, 1);
        cyc(g);
        chk("wrap_g0", g, 4'b0001);
        cyc(g);
        chk("wrap_g1", g, 4'b0100);
        for (int i = 0; i < N; i++) load(i, 1);
        cyc(g);
        chk("wrap_ptr3", g, 4'b1000);
        run(10);

        // backpressure
        load(0, 20);
        load(1, 20);
        run(4);
        out_ready = 1'b0;
        stall_data = out_data;
        for (int k = 0; k < 3; k++) begin
            cyc(g);
            chk("bp_gnt", g, 0);
            chk("bp_data", out_data, stall_data);
        end
        out_ready = 1'b1;
        run(50);
        chk("bp_drained", busy, 0);

        // reset mid-stream
        for (int i = 0; i < N; i++) load(i, 3);
        run(3);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_busy0", busy, 0);
        chk("mid_gnt", gnt, 0);
        cyc(g);
        for (int i = 0; i < N; i++) load(i, 0);
        rst_n = 1'b1;
        load(3, 1);
        req_data[3*W +: W] = 8'h3C;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!seen) begin
                cyc(g);
                if (out_valid) begin
                    seen = 1'b1;
                    chk("post_data", out_data, 8'h3C);
                    chk("post_id", out_id, 3);
                end
            end
        end
        chk("post_seen", seen, 1);
        run(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
